// File: rtl/conv_out_requant.sv
// Generic single-clock FIFO, first-word-fall-through, head reads zero when empty.
// Latency: a pushed word is visible at the head one edge after the push when the FIFO was empty.
// Backpressure: wr_rdy drops when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_vld  = (count != '0);
    assign do_pop  = rd_vld && rd_rdy;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign wr_rdy  = (count < FULL_CNT) || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Per-lane leaky ReLU, rounding right shift and int8 saturation; eight lanes packed to 64 bits.
// Latency: beat captured in S1, then S2, then written to the FIFO: pixel_valid 3 cycles after acc_valid.
// Backpressure: none upstream; words arriving at a full FIFO are dropped and flag sticky overflow.
module conv_out_requant #(
    parameter int FIFO_DEPTH = 16,
    parameter int SHIFT_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acc_valid,
    input  logic signed [31:0]            acc [0:7],
    input  logic [SHIFT_W-1:0]            shift,
    input  logic                          leaky_en,
    output logic [63:0]                   pixel_out,
    output logic                          pixel_valid,
    input  logic                          pixel_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic [7:0][31:0]   y;
    } s1_t;

    s1_t         s1_dat;
    logic        s1_vld;
    logic [63:0] s2_dat;
    logic        s2_vld;
    logic        fifo_wr_rdy;

    function automatic logic [31:0] leaky(input logic signed [31:0] x, input logic en);
        return (en && x[31]) ? 32'(x >>> 3) : x;
    endfunction

    // 33-bit intermediate keeps y + rounding bias from overflowing before the shift.
    function automatic logic [7:0] requant(input logic signed [31:0] y, input logic [SHIFT_W-1:0] sh);
        logic signed [32:0] ext;
        logic signed [32:0] rnd;
        logic signed [32:0] r;
        ext = $signed({y[31], y});
        rnd = (sh == '0) ? 33'sd0 : (33'sd1 <<< (sh - 1'b1));
        r   = (ext + rnd) >>> sh;
        if (r > 33'sd127)       return 8'h7F;
        else if (r < -33'sd128) return 8'h80;
        else                    return r[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= acc_valid;
            if (acc_valid) begin
                s1_dat.shift <= shift;
                for (int i = 0; i < 8; i++) s1_dat.y[i] <= leaky(acc[i], leaky_en);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                for (int i = 0; i < 8; i++) s2_dat[8*i +: 8] <= requant(s1_dat.y[i], s1_dat.shift);
            end
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s2_vld),
        .wr_dat (s2_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (pixel_valid),
        .rd_dat (pixel_out),
        .rd_rdy (pixel_ready),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        overflow <= 1'b0;
        else if (s2_vld && !fifo_wr_rdy) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_conv_out_requant.sv
// Directed-vector bench for conv_out_requant with hand-computed expected pixels.
module tb_conv_out_requant;
    logic               clk = 1'b0;
    logic               rst;
    logic               acc_valid;
    logic signed [31:0] acc [0:7];
    logic [4:0]         shift;
    logic               leaky_en;
    logic [63:0]        pixel_out;
    logic               pixel_valid;
    logic               pixel_ready;
    logic [4:0]         fifo_count;
    logic               overflow;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] EXP_SAT   = 64'h05_80_80_7F_7F_FF_01_00;
    localparam logic [63:0] EXP_RND   = 64'h80_7F_00_01_FE_FF_01_02;
    localparam logic [63:0] EXP_LEAKY = 64'hFE_07_FF_00_80_64_FF_FE;

    conv_out_requant #(.FIFO_DEPTH(16), .SHIFT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_valid   (acc_valid),
        .acc         (acc),
        .shift       (shift),
        .leaky_en    (leaky_en),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] lanes(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic send_beat(input logic [255:0] v, input logic [4:0] sh, input logic lk);
        @(negedge clk);
        acc_valid = 1'b1;
        for (int i = 0; i < 8; i++) acc[i] = v[32*i +: 32];
        shift    = sh;
        leaky_en = lk;
    endtask

    task automatic idle;
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    // One beat with pixel_ready high: checks the 3-cycle latency and the packed result.
    task automatic run_vec(input string tag, input logic [255:0] v, input logic [4:0] sh,
                           input logic lk, input logic [63:0] exp);
        send_beat(v, sh, lk);
        idle();
        check({tag, "_lat0"}, 64'(pixel_valid), 64'd0);
        @(negedge clk);
        check({tag, "_lat1"}, 64'(pixel_valid), 64'd0);
        @(negedge clk);
        check({tag, "_lat2"}, 64'(pixel_valid), 64'd1);
        check({tag, "_data"}, pixel_out, exp);
    endtask

    logic [255:0] v_sat, v_rnd, v_leaky;
    logic [63:0]  exp_word;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; acc_valid = 1'b0; shift = '0; leaky_en = 1'b0; pixel_ready = 1'b1;
        for (int i = 0; i < 8; i++) acc[i] = '0;
        v_sat   = lanes(0, 1, -1, 127, 128, -128, -129, 5);
        v_rnd   = lanes(24, 23, -24, -25, 8, 7, 32'h7FFFFFFF, 32'h80000000);
        v_leaky = lanes(-16, -1, 100, -1024, 0, -8, 7, -9);

        #1;
        check("rst_valid", 64'(pixel_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_pixel", pixel_out, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_vec("sat",   v_sat,   5'd0, 1'b0, EXP_SAT);
        run_vec("round", v_rnd,   5'd4, 1'b0, EXP_RND);
        run_vec("leaky", v_leaky, 5'd0, 1'b1, EXP_LEAKY);

        // Back-to-back beats, each carrying its own shift/leaky setting.
        send_beat(v_sat, 5'd0, 1'b0);
        send_beat(v_rnd, 5'd4, 1'b0);
        send_beat(v_leaky, 5'd0, 1'b1);
        idle();
        check("b2b_0", pixel_out, EXP_SAT);
        @(negedge clk);
        check("b2b_1", pixel_out, EXP_RND);
        @(negedge clk);
        check("b2b_2", pixel_out, EXP_LEAKY);
        @(negedge clk);
        check("b2b_empty", 64'(pixel_valid), 64'd0);

        // Backpressure: 17 beats into a 16-deep FIFO with pixel_ready low.
        pixel_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_beat(lanes(i, 0, 0, 0, 0, 0, 0, 0), 5'd0, 1'b0);
        idle();
        @(negedge clk);
        check("bp_cnt16", 64'(fifo_count), 64'd16);
        check("bp_ovf_pre", 64'(overflow), 64'd0);
        @(negedge clk);
        check("bp_cnt17", 64'(fifo_count), 64'd16);
        check("bp_ovf", 64'(overflow), 64'd1);
        check("bp_hold", pixel_out, 64'd0);
        pixel_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            exp_word = 64'(j);
            check("bp_drain_vld", 64'(pixel_valid), 64'd1);
            check("bp_drain_dat", pixel_out, exp_word);
            @(negedge clk);
        end
        check("bp_empty", 64'(pixel_valid), 64'd0);
        check("bp_ovf_sticky", 64'(overflow), 64'd1);

        // Reset with data in S1, S2 and the FIFO.
        pixel_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(lanes(50 + i, 0, 0, 0, 0, 0, 0, 0), 5'd0, 1'b0);
        @(negedge clk);
        check("mid_cnt", 64'(fifo_count), 64'd2);
        rst = 1'b0;
        acc_valid = 1'b0;
        #1;
        check("mid_rst_valid", 64'(pixel_valid), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_ovf",   64'(overflow), 64'd0);
        check("mid_rst_pixel", pixel_out, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(pixel_valid), 64'd0);
        end

        // Full FIFO with a pop on the same edge as the 17th write.
        for (int i = 0; i < 16; i++) send_beat(lanes(i, 0, 0, 0, 0, 0, 0, 0), 5'd0, 1'b0);
        send_beat(lanes(100, 0, 0, 0, 0, 0, 0, 0), 5'd0, 1'b0);
        idle();
        @(negedge clk);
        check("pp_full", 64'(fifo_count), 64'd16);
        pixel_ready = 1'b1;
        @(negedge clk);
        pixel_ready = 1'b0;
        check("pp_cnt", 64'(fifo_count), 64'd16);
        check("pp_ovf", 64'(overflow), 64'd0);
        check("pp_head", pixel_out, 64'd1);
        pixel_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            exp_word = (j < 15) ? 64'(j + 1) : 64'd100;
            check("pp_drain_vld", 64'(pixel_valid), 64'd1);
            check("pp_drain_dat", pixel_out, exp_word);
            @(negedge clk);
        end
        check("pp_empty", 64'(pixel_valid), 64'd0);
        check("pp_cnt0", 64'(fifo_count), 64'd0);
        check("pp_ovf_end", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_out_requant.md
# conv_out_requant

Output-side companion to the 1x1 convolution array. Each `acc_valid` beat carries eight 32-bit signed accumulators, one per output channel. The block applies optional leaky ReLU, rounding right-shift and int8 saturation to each lane, then packs the eight results into one 64-bit pixel in the same byte layout the convolution array consumes. The PE array has no backpressure, so results are buffered in a FIFO behind a valid/ready output handshake.

## Interface
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥4.
- `SHIFT_W`, 5: width of the requantization shift amount.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `acc_valid`  in  1  one beat of accumulators this cycle; no ready, never stalled.
- `acc`  in  32×8 (`[0:7]`)  signed accumulators, lane i = output channel i.
- `shift`  in  SHIFT_W  right-shift amount, sampled with each beat.
- `leaky_en`  in  1  enables leaky ReLU, sampled with each beat.
- `pixel_out`  out  64  packed int8 result; lane i in bits [8i+7:8i].
- `pixel_valid`  out  1  FIFO non-empty.
- `pixel_ready`  in  1  downstream accepts `pixel_out` when high with `pixel_valid`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; a beat was dropped because the FIFO was full.

## Operation
- **Stage 1 (S1):** registers all lanes plus `shift`.
  - `leaky_en`=1 and x<0: y = x >>> 3 (arithmetic shift, floor, slope 1/8).
  - Otherwise y = x.
- **Stage 2 (S2):** rounding shift and saturation per lane.
  - Computed at 33 bits: r = (y + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
  - This is round-half-up toward +inf.
  - Result saturates to [-128, 127]. S2 registers the packed 64-bit word.
- **FIFO:** S2 output is written when the S2 valid bit is set.
  - First-word-fall-through; `pixel_out` = head entry.
- **Pop:** occurs on a cycle with `pixel_valid` && `pixel_ready`.
- **Write accept:** a write is accepted if `fifo_count` < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - `overflow` is cleared only by reset.
- **Push and pop in the same cycle:** `fifo_count` is unchanged; order is preserved.
- **Pointers** wrap modulo FIFO_DEPTH. `fifo_count` ranges 0..FIFO_DEPTH.
- **`pixel_out`** is don't-care when `pixel_valid`=0; the bench must not check it then.
- **No state machine beyond pipeline valid bits.** S1 and S2 each hold a valid bit and never stall.

## Timing
- **Reset (`rst`=0):** takes effect immediately, asynchronously.
  - `pixel_valid`=0, `fifo_count`=0, `overflow`=0, `pixel_out`=0.
  - S1/S2 valid bits and FIFO pointers are cleared.
  - Data in flight is discarded; no partial word is emitted after release.
- **Latency:** beat on edge N is captured in S1 at N, in S2 at N+1, and written to the FIFO at N+2.
  - `pixel_valid` is high after edge N+2 when the FIFO was empty: 3 cycles, input to output.
- **Throughput:** one beat per cycle, back-to-back, with `pixel_ready` held high.
- **Per-beat config:** `shift` and `leaky_en` changes take effect on the next beat. In-flight beats keep their own sampled values.
- **Handshake:** `pixel_out` and `pixel_valid` are stable while `pixel_valid`=1 and `pixel_ready`=0.
- **Full FIFO with `pixel_ready` low:** the next S2 write is dropped, and `overflow` rises on the same edge.

## Test plan
- **Saturation, shift=0, leaky off:**
  - Stimulus: acc lanes 0..7 = {0, 1, -1, 127, 128, -128, -129, 5}.
  - Required: `pixel_out` = 64'h05_80_80_7F_7F_FF_01_00.
  - Required: `pixel_valid` rises 3 cycles after `acc_valid`.
- **Rounding, shift=4, leaky off:**
  - Stimulus: lanes = {24, 23, -24, -25, 8, 7, 0x7FFFFFFF, 0x80000000}.
  - Required bytes: {02, 01, FF, FE, 01, 00, 7F, 80}.
- **Leaky, shift=0, leaky on:**
  - Stimulus: lanes = {-16, -1, 100, -1024, 0, -8, 7, -9}.
  - Required bytes: {FE, FF, 64, 80, 00, FF, 07, FE}.
- **Backpressure and overflow:**
  - Stimulus: `pixel_ready`=0, 17 consecutive beats, lane0 = beat index.
  - Required: `fifo_count`=16 and `overflow`=1 after the 17th write slot.
  - Then raise `pixel_ready`: 16 words drain in order 0..15; `overflow` stays 1.
- **Full with simultaneous pop and push:**
  - Stimulus: fill to 16, then `pixel_ready`=1 on the same cycle a write arrives.
  - Required: `fifo_count` stays 16, `overflow` stays 0, no data lost.
- **Reset mid-stream:**
  - Stimulus: `rst`=0 asynchronously while S1, S2 and the FIFO all hold data.
  - Required: outputs are at reset values immediately. After release with no input beats, `pixel_valid` stays 0.
